// File: rtl/ball_motion_ctrl.sv
// Velocity/strobe controller for the position integrator: tick strobe, tilt acceleration, wall bounce.
// Strobes are registered; a CHECK decision lands one cycle later. There is no backpressure, and i_stop aborts to IDLE on the next edge.
module ball_motion_ctrl #(
    parameter int POSITION_SHIFT = 8,
    parameter int TICK_DIV       = 50000,
    parameter int POS_MIN        = 0,
    parameter int POS_MAX        = 100,
    parameter int START_POS      = 50,
    parameter int ACCEL_STEP     = 16,
    parameter int V_MAX          = 1024,
    parameter int BOUNCE_SHIFT   = 1
) (
    input  logic        CLK,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [3:0]  i_tilt,
    input  logic [31:0] i_pos,
    output logic        o_calc_time,
    output logic [31:0] o_velocity,
    output logic        o_rst0,
    output logic [9:0]  o_rst0_value,
    output logic        o_rst1,
    output logic        o_rst2,
    output logic        o_hit_left,
    output logic        o_hit_right,
    output logic [1:0]  o_state
);

    generate
        if (TICK_DIV < 4 || POSITION_SHIFT < 0 || POSITION_SHIFT > 31) begin : g_bad_param
            $error("ball_motion_ctrl: TICK_DIV must be >= 4 and POSITION_SHIFT within 0..31");
        end
    endgenerate

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]     CNT_LAST  = CW'(TICK_DIV - 1);
    localparam logic signed [32:0] VMAX_X   = 33'(V_MAX);
    localparam logic signed [32:0] VMIN_X   = -33'(V_MAX);
    localparam logic signed [32:0] STEP_X   = 33'(ACCEL_STEP);
    localparam logic signed [31:0] POS_MIN_S = 32'(POS_MIN);
    localparam logic signed [31:0] POS_MAX_S = 32'(POS_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t             state_q, state_n;
    logic [CW-1:0]      cnt_q, cnt_n;
    logic signed [31:0] vel_q, vel_n;
    logic               calc_q, calc_n;
    logic               rst0_q, rst0_n;
    logic               rst1_q, rst1_n;
    logic               rst2_q, rst2_n;

    logic signed [31:0] pos_s;
    logic signed [32:0] tilt_x;
    logic signed [32:0] accel_x;
    logic signed [32:0] sum_x;
    logic signed [31:0] vel_acc;
    logic signed [31:0] vel_bounce;
    logic               cnt_last;
    logic               hit_left_cond;
    logic               hit_right_cond;

    // Acceleration is summed on 33 bits so saturation sees the true overflow.
    always_comb begin
        pos_s      = $signed(i_pos);
        tilt_x     = $signed({{29{i_tilt[3]}}, i_tilt});
        accel_x    = tilt_x * STEP_X;
        sum_x      = $signed({vel_q[31], vel_q}) + accel_x;
        vel_acc    = sum_x[31:0];
        if (sum_x > VMAX_X) begin
            vel_acc = VMAX_X[31:0];
        end else if (sum_x < VMIN_X) begin
            vel_acc = VMIN_X[31:0];
        end
        vel_bounce     = -(vel_q >>> BOUNCE_SHIFT);
        hit_left_cond  = (pos_s <= POS_MIN_S) && (vel_q < 0);
        hit_right_cond = (pos_s >= POS_MAX_S) && (vel_q > 0);
        cnt_last       = (cnt_q == CNT_LAST);
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        vel_n   = vel_q;
        rst1_n  = 1'b0;
        rst2_n  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_n = '0;
                if (i_start && !i_stop) begin
                    state_n = S_LOAD;
                    vel_n   = '0;
                end
            end
            S_LOAD: begin
                cnt_n   = '0;
                state_n = S_RUN;
            end
            S_RUN: begin
                cnt_n = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                cnt_n   = cnt_last ? '0 : cnt_q + 1'b1;
                state_n = S_RUN;
                if (hit_left_cond) begin
                    rst1_n = 1'b1;
                    vel_n  = vel_bounce;
                end else if (hit_right_cond) begin
                    rst2_n = 1'b1;
                    vel_n  = vel_bounce;
                end else begin
                    vel_n  = vel_acc;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                vel_n   = '0;
            end
        endcase

        // Abort wins over everything, including a clamp decided this cycle.
        if (state_q != S_IDLE && i_stop) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            vel_n   = '0;
            rst1_n  = 1'b0;
            rst2_n  = 1'b0;
        end

        rst0_n = (state_n == S_LOAD);
        calc_n = (state_n == S_RUN) && (cnt_n == CNT_LAST);
    end

    always_ff @(posedge CLK or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vel_q   <= '0;
            calc_q  <= 1'b0;
            rst0_q  <= 1'b0;
            rst1_q  <= 1'b0;
            rst2_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            vel_q   <= vel_n;
            calc_q  <= calc_n;
            rst0_q  <= rst0_n;
            rst1_q  <= rst1_n;
            rst2_q  <= rst2_n;
        end
    end

    assign o_calc_time  = calc_q;
    assign o_velocity   = vel_q;
    assign o_rst0       = rst0_q;
    assign o_rst0_value = 10'(START_POS);
    assign o_rst1       = rst1_q;
    assign o_rst2       = rst2_q;
    assign o_hit_left   = rst1_q;
    assign o_hit_right  = rst2_q;
    assign o_state      = state_q;

endmodule
